// File: rtl/zelda_draw_pkg.sv
// Shared definitions for the Zelda draw pipeline: VGA field widths, the frame
// sequencer state encoding and a helper for index widths.
package zelda_draw_pkg;

  localparam int unsigned X_W = 9;
  localparam int unsigned Y_W = 8;
  localparam int unsigned C_W = 6;

  typedef enum logic [2:0] {
    S_WAIT,
    S_SELECT,
    S_DRAW,
    S_RELEASE,
    S_DONE
  } draw_state_e;

  // A single layer still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_draw_sequencer_if.sv
// Per-layer draw channels plus the registered VGA adapter outputs.
// master = sequencer side, slave = draw layers / VGA adapter side.
interface layer_draw_sequencer_if #(
  parameter int unsigned N_LAYERS = 3
);
  import zelda_draw_pkg::*;

  logic [X_W*N_LAYERS-1:0] layer_x;
  logic [Y_W*N_LAYERS-1:0] layer_y;
  logic [C_W*N_LAYERS-1:0] layer_colour;
  logic [N_LAYERS-1:0]     layer_write;
  logic [N_LAYERS-1:0]     layer_done;
  logic [N_LAYERS-1:0]     layer_draw;
  logic [X_W-1:0]          x_position;
  logic [Y_W-1:0]          y_position;
  logic [C_W-1:0]          colour;
  logic                    VGA_enable;

  modport master (
    input  layer_x, layer_y, layer_colour, layer_write, layer_done,
    output layer_draw, x_position, y_position, colour, VGA_enable
  );

  modport slave (
    output layer_x, layer_y, layer_colour, layer_write, layer_done,
    input  layer_draw, x_position, y_position, colour, VGA_enable
  );

endinterface

// File: rtl/frame_tick_gen.sv
// Free-running frame pacer: counts 0..FRAME_COUNT-1 while enabled and flags
// the last count as the frame tick; dropping enable parks the counter at 0.
module frame_tick_gen #(
  parameter int unsigned FRAME_COUNT = 1666666
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  output logic tick
);
  localparam int unsigned     CNT_W = $clog2(FRAME_COUNT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_COUNT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!enable || cnt_q == LAST) cnt_d = '0;
  end

  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/layer_draw_sequencer.sv
// Frame scheduler: grants enabled draw layers in index order once per frame
// tick, muxes the granted layer onto the VGA outputs and tracks overruns.
module layer_draw_sequencer
  import zelda_draw_pkg::*;
#(
  parameter int unsigned N_LAYERS    = 3,
  parameter int unsigned FRAME_COUNT = 1666666,
  parameter int unsigned SKIP_W      = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [N_LAYERS-1:0]   layer_mask,
  layer_draw_sequencer_if.master layers,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun,
  output logic [SKIP_W-1:0]     frame_skips,
  input  logic                  clear_overrun
);
  localparam int unsigned      IDX_W    = idx_width(N_LAYERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LAYERS - 1);

  draw_state_e         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_LAYERS-1:0] mask_q, mask_d;
  logic [N_LAYERS-1:0] draw_q, draw_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [C_W-1:0]      col_q, col_d;
  logic                vga_en_q, vga_en_d;
  logic                overrun_q, overrun_d;
  logic [SKIP_W-1:0]   skips_q, skips_d;
  logic                tick;

  frame_tick_gen #(.FRAME_COUNT(FRAME_COUNT)) u_tick (
    .clock  (clock),
    .resetn (resetn),
    .enable (enable),
    .tick   (tick)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    draw_d   = draw_q;
    x_d      = x_q;
    y_d      = y_q;
    col_d    = col_q;
    vga_en_d = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (tick) begin
          mask_d  = layer_mask;
          idx_d   = '0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (mask_q[idx_q]) begin
          draw_d        = '0;
          draw_d[idx_q] = 1'b1;
          state_d       = S_DRAW;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DRAW: begin
        x_d      = layers.layer_x[idx_q*X_W +: X_W];
        y_d      = layers.layer_y[idx_q*Y_W +: Y_W];
        col_d    = layers.layer_colour[idx_q*C_W +: C_W];
        vga_en_d = layers.layer_write[idx_q];
        if (layers.layer_done[idx_q]) begin
          draw_d   = '0;
          vga_en_d = 1'b0;
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_SELECT;
        end
      end
      S_DONE:  state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  // A tick landing in the same cycle as clear_overrun restarts the count at 1.
  always_comb begin
    overrun_d = overrun_q;
    skips_d   = skips_q;
    if (tick && state_q != S_WAIT) begin
      overrun_d = 1'b1;
      if (clear_overrun)      skips_d = SKIP_W'(1);
      else if (skips_q != '1) skips_d = skips_q + SKIP_W'(1);
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
      skips_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_WAIT;
      idx_q     <= '0;
      mask_q    <= '0;
      draw_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      col_q     <= '0;
      vga_en_q  <= 1'b0;
      overrun_q <= 1'b0;
      skips_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      draw_q    <= draw_d;
      x_q       <= x_d;
      y_q       <= y_d;
      col_q     <= col_d;
      vga_en_q  <= vga_en_d;
      overrun_q <= overrun_d;
      skips_q   <= skips_d;
    end
  end

  assign layers.layer_draw = draw_q;
  assign layers.x_position = x_q;
  assign layers.y_position = y_q;
  assign layers.colour     = col_q;
  assign layers.VGA_enable = vga_en_q;
  assign busy              = (state_q != S_WAIT);
  assign frame_done        = (state_q == S_DONE);
  assign overrun           = overrun_q;
  assign frame_skips       = skips_q;

endmodule

// File: tb/tb_layer_draw_sequencer.sv
// Directed bench for layer_draw_sequencer: three layer models that each write
// four pixels per grant, plus frame pacing, masking, overrun and reset cases.
module tb_layer_draw_sequencer;
  localparam int N  = 3;
  localparam int FC = 100;

  logic       clock = 1'b0;
  logic       resetn, enable, clear_overrun;
  logic [2:0] layer_mask;
  logic       busy, frame_done, overrun;
  logic [7:0] frame_skips;

  layer_draw_sequencer_if #(.N_LAYERS(N)) bus ();

  layer_draw_sequencer #(.N_LAYERS(N), .FRAME_COUNT(FC), .SKIP_W(8)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .enable        (enable),
    .layer_mask    (layer_mask),
    .layers        (bus),
    .busy          (busy),
    .frame_done    (frame_done),
    .overrun       (overrun),
    .frame_skips   (frame_skips),
    .clear_overrun (clear_overrun)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // layer models and VGA observer state (written only by the negedge block)
  bit [N-1:0] hold = '0;
  int   cnt [N] = '{default: 0};
  int   pk  [N] = '{default: 0};
  bit   lw  [N] = '{default: 1'b0};
  bit   ld  [N] = '{default: 1'b0};
  int   wr_cnt [N] = '{default: 0};
  int   gcnt   [N] = '{default: 0};
  int   glog [$];
  bit   exp_en = 1'b0;
  logic [8:0] exp_x = '0;
  logic [7:0] exp_y = '0;
  logic [5:0] exp_c = '0;
  int   exp_src = 0;
  int   data_err = 0, onehot_err = 0, fd_cnt = 0, fd_last = 0, fd_prev = 0, cyc = 0;
  logic [N-1:0] prev_draw = '0;

  function automatic logic [8:0] pix_x(input int i, input int k);
    return 9'(i * 100 + k * 7 + 5);
  endfunction
  function automatic logic [7:0] pix_y(input int i, input int k);
    return 8'(i * 40 + k * 3 + 1);
  endfunction
  function automatic logic [5:0] pix_c(input int i, input int k);
    return 6'(i * 16 + k + 2);
  endfunction

  always @(negedge clock) begin
    int src;
    cyc++;
    if (resetn) begin
      if (bus.VGA_enable !== exp_en) data_err++;
      else if (exp_en && {bus.x_position, bus.y_position, bus.colour} !== {exp_x, exp_y, exp_c})
        data_err++;
      if (exp_en && bus.VGA_enable === 1'b1) wr_cnt[exp_src]++;
      if ($countones(bus.layer_draw) > 1) onehot_err++;
      if (prev_draw == '0 && bus.layer_draw != '0) begin
        src = 0;
        for (int i = 0; i < N; i++) if (bus.layer_draw[i]) src = i;
        glog.push_back(src);
        gcnt[src]++;
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        fd_prev = fd_last;
        fd_last = cyc;
      end
    end
    prev_draw = resetn ? bus.layer_draw : '0;
    exp_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (resetn && bus.layer_draw[i]) begin
        if (cnt[i] < 4) begin
          pk[i] = cnt[i];
          cnt[i]++;
          lw[i] = 1'b1;
          ld[i] = 1'b0;
        end else begin
          lw[i] = 1'b0;
          ld[i] = !hold[i];
        end
        exp_en  = lw[i];
        exp_x   = pix_x(i, pk[i]);
        exp_y   = pix_y(i, pk[i]);
        exp_c   = pix_c(i, pk[i]);
        exp_src = i;
      end else begin
        cnt[i] = 0;
        lw[i]  = 1'b0;
        ld[i]  = 1'b0;
      end
      bus.layer_x[i*9 +: 9]      = pix_x(i, pk[i]);
      bus.layer_y[i*8 +: 8]      = pix_y(i, pk[i]);
      bus.layer_colour[i*6 +: 6] = pix_c(i, pk[i]);
      bus.layer_write[i]         = lw[i];
      bus.layer_done[i]          = ld[i];
    end
  end

  function automatic logic [37:0] outs_vec();
    return {busy, frame_done, overrun, frame_skips, bus.layer_draw, bus.VGA_enable,
            bus.x_position, bus.y_position, bus.colour};
  endfunction

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_busy_rise(input int max, output bit ok);
    logic prev;
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      prev = busy;
      step();
      if (!prev && busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fd(input int max, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      step();
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    bit stray;
    resetn = 1'b0; enable = 1'b0; layer_mask = 3'b111; clear_overrun = 1'b0;
    step(); step();
    n_checks++;
    if (outs_vec() !== '0) begin n_fail++; $display("FAIL reset_init: got %h expected 0", outs_vec()); end
    resetn = 1'b1; enable = 1'b1;
    wait_busy_rise(150, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reset_first_tick: got timeout expected busy rise"); end
    step(); step(); step();
    n_checks++;
    if (bus.layer_draw !== 3'b001) begin n_fail++; $display("FAIL reset_pre_draw: got %b expected 001", bus.layer_draw); end
    #1 resetn = 1'b0;
    #1;
    n_checks++;
    if (outs_vec() !== '0) begin n_fail++; $display("FAIL reset_async: got %h expected 0", outs_vec()); end
    step(); step(); step();
    resetn = 1'b1;
    stray = 1'b0;
    repeat (90) begin
      step();
      stray |= busy | (|bus.layer_draw);
    end
    n_checks++;
    if (stray !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got activity %0d expected 0", stray); end
  endtask

  task automatic test_mask_all();
    bit ok;
    int g0, d0, o0, f0;
    int w0 [N];
    layer_mask = 3'b111;
    g0 = glog.size(); d0 = data_err; o0 = onehot_err; f0 = fd_cnt; w0 = wr_cnt;
    wait_busy_rise(150, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL all_tick: got timeout expected busy rise"); end
    wait_fd(60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL all_done: got timeout expected frame_done"); end
    step();
    n_checks++;
    if (glog.size() - g0 !== 3) begin
      n_fail++; $display("FAIL all_grant_cnt: got %0d expected 3", glog.size() - g0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (glog[g0+k] !== k) begin n_fail++; $display("FAIL all_order[%0d]: got %0d expected %0d", k, glog[g0+k], k); end
      end
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (wr_cnt[i] - w0[i] !== 4) begin n_fail++; $display("FAIL all_writes[%0d]: got %0d expected 4", i, wr_cnt[i] - w0[i]); end
    end
    n_checks++;
    if (data_err !== d0) begin n_fail++; $display("FAIL all_vga_data: got %0d errors expected 0", data_err - d0); end
    n_checks++;
    if (onehot_err !== o0) begin n_fail++; $display("FAIL all_onehot: got %0d errors expected 0", onehot_err - o0); end
    n_checks++;
    if (fd_cnt - f0 !== 1) begin n_fail++; $display("FAIL all_fd_pulses: got %0d expected 1", fd_cnt - f0); end
    wait_fd(150, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL all_done2: got timeout expected frame_done"); end
    step();
    n_checks++;
    if (fd_last - fd_prev !== FC) begin n_fail++; $display("FAIL all_fd_period: got %0d expected %0d", fd_last - fd_prev, FC); end
  endtask

  task automatic test_mask_101();
    bit ok;
    int g0, d0, g1;
    int w0 [N];
    layer_mask = 3'b101;
    g0 = glog.size(); d0 = data_err; g1 = gcnt[1]; w0 = wr_cnt;
    wait_busy_rise(150, ok);
    wait_fd(60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL m101_done: got timeout expected frame_done"); end
    step();
    n_checks++;
    if (glog.size() - g0 !== 2) begin
      n_fail++; $display("FAIL m101_grant_cnt: got %0d expected 2", glog.size() - g0);
    end else begin
      n_checks++;
      if (glog[g0] !== 0 || glog[g0+1] !== 2) begin
        n_fail++; $display("FAIL m101_order: got %0d,%0d expected 0,2", glog[g0], glog[g0+1]);
      end
    end
    n_checks++;
    if (gcnt[1] !== g1) begin n_fail++; $display("FAIL m101_layer1: got %0d grants expected 0", gcnt[1] - g1); end
    n_checks++;
    if ({wr_cnt[0] - w0[0], wr_cnt[1] - w0[1], wr_cnt[2] - w0[2]} !== {32'd4, 32'd0, 32'd4}) begin
      n_fail++; $display("FAIL m101_writes: got %0d/%0d/%0d expected 4/0/4",
                         wr_cnt[0] - w0[0], wr_cnt[1] - w0[1], wr_cnt[2] - w0[2]);
    end
    n_checks++;
    if (data_err !== d0) begin n_fail++; $display("FAIL m101_vga_data: got %0d errors expected 0", data_err - d0); end
  endtask

  task automatic test_mask_000();
    bit ok;
    int g0, w0, k;
    layer_mask = 3'b000;
    g0 = glog.size(); w0 = wr_cnt[0] + wr_cnt[1] + wr_cnt[2];
    wait_busy_rise(150, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL m000_tick: got timeout expected busy rise"); end
    k = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      k++;
      if (frame_done) break;
    end
    n_checks++;
    if (k !== 3) begin n_fail++; $display("FAIL m000_fd_latency: got %0d expected 3", k); end
    step();
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL m000_fd_pulse: got %0d expected 0", frame_done); end
    n_checks++;
    if (glog.size() !== g0 || wr_cnt[0] + wr_cnt[1] + wr_cnt[2] !== w0) begin
      n_fail++; $display("FAIL m000_quiet: got %0d grants %0d writes expected 0 0",
                         glog.size() - g0, wr_cnt[0] + wr_cnt[1] + wr_cnt[2] - w0);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    layer_mask = 3'b111;
    n_checks++;
    if ({overrun, frame_skips} !== 9'd0) begin n_fail++; $display("FAIL ovr_pre: got %0d/%0d expected 0/0", overrun, frame_skips); end
    hold = 3'b001;
    wait_busy_rise(150, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ovr_tick: got timeout expected busy rise"); end
    repeat (250) step();
    hold = '0;
    wait_fd(60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ovr_done: got timeout expected frame_done"); end
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %0d expected 1", overrun); end
    n_checks++;
    if (frame_skips !== 8'd2) begin n_fail++; $display("FAIL ovr_skips: got %0d expected 2", frame_skips); end
    hold = 3'b001;
    wait_busy_rise(150, ok);
    repeat (199) step();
    n_checks++;
    if (frame_skips !== 8'd3) begin n_fail++; $display("FAIL ovr_skips3: got %0d expected 3", frame_skips); end
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    n_checks++;
    if ({overrun, frame_skips} !== {1'b1, 8'd1}) begin
      n_fail++; $display("FAIL ovr_clear_tick: got %0d/%0d expected 1/1", overrun, frame_skips);
    end
    hold = '0;
    wait_fd(60, ok);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    n_checks++;
    if ({overrun, frame_skips} !== 9'd0) begin
      n_fail++; $display("FAIL ovr_clear: got %0d/%0d expected 0/0", overrun, frame_skips);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    bit stray;
    int k;
    layer_mask = 3'b111;
    wait_busy_rise(150, ok);
    repeat (3) step();
    enable = 1'b0;
    wait_fd(60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL drop_frame_done: got timeout expected frame_done"); end
    stray = 1'b0;
    repeat (250) begin
      step();
      stray |= busy;
    end
    n_checks++;
    if (stray !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got busy %0d expected 0", stray); end
    enable = 1'b1;
    k = 0;
    for (int j = 0; j < 200; j++) begin
      step();
      k++;
      if (busy) break;
    end
    n_checks++;
    if (k !== FC) begin n_fail++; $display("FAIL drop_restart: got %0d cycles expected %0d", k, FC); end
    n_checks++;
    if (data_err !== 0) begin n_fail++; $display("FAIL total_vga_data: got %0d errors expected 0", data_err); end
  endtask

  initial begin
    test_reset();
    test_mask_all();
    test_mask_101();
    test_mask_000();
    test_overrun();
    test_enable_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end

endmodule
